// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle add/subtract unit. The WIDTH-bit operands are added CHUNK bits
// per clock, least-significant chunk first, with the carry held in a register
// between chunks. Each add only needs a CHUNK-bit carry chain, so wide
// operands still close timing. The cost is NCH = WIDTH/CHUNK cycles of
// latency per operation. A start/busy/done handshake lets several datapath
// controllers share one adder.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; S/Cout/V hold the last result
//   RUN   | one chunk is added per clock; counter selects the chunk
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits added per clock (CHUNK == WIDTH gives a one-cycle op)
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while idle
//   Sub    in   1      0: S = A + B + Cin, 1: S = A - B
//   A      in   WIDTH  operand A, captured on an accepted start
//   B      in   WIDTH  operand B, captured on an accepted start
//   Cin    in   1      carry in for add, captured on an accepted start
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, S/Cout/V were updated
//   S      out  WIDTH  result, held until the next completion
//   Cout   out  1      carry out of the MSB (sub: 1 = no borrow)
//   V      out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   finish;

  // Operand registers shift right by CHUNK every RUN cycle, so the chunk
  // being added is always in the low bits. This avoids a variable
  // part-select indexed by the counter.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // The operand MSBs are gone from a_q/bx_q by the last chunk. The overflow
  // rule still needs them, so they are kept from the start of the operation.
  logic             a_msb_q;
  logic             bx_msb_q;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             v_q;
  logic             done_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_out;
  logic [WIDTH-1:0] res_next;
  logic             v_next;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CHUNK) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One chunk of the addition
  // ---------------------------------------------------------------------------
  assign a_chunk = a_q[CHUNK-1:0];
  assign b_chunk = bx_q[CHUNK-1:0];

  assign {carry_out, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                + {{CHUNK{1'b0}}, carry_q};

  // Each new sum chunk enters at the top of the result register. After NCH
  // chunks the first chunk has reached bit 0, so the register holds the full
  // sum in its normal bit order.
  assign res_next = (res_q >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));

  // Overflow happens when both operands have the same sign and the result
  // sign differs from it. For subtract, bx_msb_q is the sign of ~B.
  assign v_next = (a_msb_q == bx_msb_q) && (res_next[WIDTH-1] != a_msb_q);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      bx_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Subtract is A + ~B + 1, so B is inverted and the carry is forced to 1.
        a_q      <= A;
        bx_q     <= Sub ? ~B : B;
        carry_q  <= Sub ? 1'b1 : Cin;
        cnt_q    <= '0;
        res_q    <= '0;
        a_msb_q  <= A[WIDTH-1];
        bx_msb_q <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
      end else if (state_q == RUN) begin
        a_q     <= a_q >> CHUNK;
        bx_q    <= bx_q >> CHUNK;
        res_q   <= res_next;
        carry_q <= carry_out;
        cnt_q   <= cnt_q + CW'(1);
        if (finish) begin
          s_q    <= res_next;
          cout_q <= carry_out;
          v_q    <= v_next;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//
// Three adder instances share one set of operand inputs:
//   idx 0: WIDTH=16, CHUNK=4
//   idx 1: WIDTH=16, CHUNK=16
//   idx 2: WIDTH=8,  CHUNK=1
// Each instance has its own start bit. Expected results come from an integer
// arithmetic model of A+B+Cin / A-B and from the known values of the
// directed cases.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic        sub;
  logic [15:0] a, b;
  logic        cin;

  logic        busy0, done0, cout0, v0;
  logic [15:0] s0;
  logic        busy1, done1, cout1, v1;
  logic [15:0] s1;
  logic        busy2, done2, cout2, v2;
  logic [7:0]  s2;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .busy(busy0), .done(done0), .S(s0), .Cout(cout0), .V(v0)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_n8 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .Sub(sub), .A(a[7:0]), .B(b[7:0]), .Cin(cin),
    .busy(busy2), .done(done2), .S(s2), .Cout(cout2), .V(v2)
  );

  int          sel = 0;
  logic        busy_sel, done_sel, cout_sel, v_sel;
  logic [15:0] s_sel;

  always_comb begin
    busy_sel = busy0;
    done_sel = done0;
    s_sel    = s0;
    cout_sel = cout0;
    v_sel    = v0;
    case (sel)
      1: begin
        busy_sel = busy1; done_sel = done1; s_sel = s1; cout_sel = cout1; v_sel = v1;
      end
      2: begin
        busy_sel = busy2; done_sel = done2; s_sel = {8'h00, s2}; cout_sel = cout2; v_sel = v2;
      end
      default: ;
    endcase
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] last_s    [3];
  logic        last_cout [3];
  logic        last_v    [3];
  logic [15:0] exp_s;
  logic        exp_cout, exp_v;

  function automatic int width_of(int idx);
    return (idx == 2) ? 8 : 16;
  endfunction

  function automatic int nch_of(int idx);
    case (idx)
      1:       return 1;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model written as plain integer arithmetic on w-bit operands.
  task automatic model(input int w, input bit sb, input logic [15:0] a_in,
                       input logic [15:0] b_in, input bit c_in,
                       output logic [15:0] s_o, output logic c_o, output logic v_o);
    longint md, ua, ub, sa, sbv, full, r, s_l;
    md  = longint'(1) << w;
    ua  = longint'(a_in) & (md - 1);
    ub  = longint'(b_in) & (md - 1);
    sa  = (ua >= md / 2) ? ua - md : ua;
    sbv = (ub >= md / 2) ? ub - md : ub;
    if (!sb) begin
      full = ua + ub + longint'(c_in);
      c_o  = (full >= md);
      s_l  = full % md;
      r    = sa + sbv + longint'(c_in);
    end else begin
      full = ua - ub;
      c_o  = (ua >= ub);
      s_l  = (full + md) % md;
      r    = sa - sbv;
    end
    v_o = (r >= md / 2) || (r < -(md / 2));
    s_o = 16'(s_l);
  endtask

  // Call away from a rising edge. Returns at the falling edge after the
  // accept edge.
  task automatic launch(int idx, bit sb, logic [15:0] av, logic [15:0] bv, bit cv);
    sel = idx;
    sub = sb; a = av; b = bv; cin = cv;
    start[idx] = 1'b1;
    model(width_of(idx), sb, av, bv, cv, exp_s, exp_cout, exp_v);
    @(posedge clk);
    @(negedge clk);
    start = 3'b000;
    check("busy_after_accept", 32'(busy_sel), 32'd1);
  endtask

  // Counts rising edges after the accept edge until done. While waiting it
  // also checks that the previous result holds. Returns at the falling edge
  // of the done cycle.
  task automatic wait_done(string tag, int exp_lat);
    int cyc = 0;
    while (!done_sel && cyc < 40) begin
      check({tag, "_hold"}, 32'(s_sel), 32'(last_s[sel]));
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_done"}, 32'(done_sel), 32'd1);
    check({tag, "_busy"}, 32'(busy_sel), 32'd0);
    check({tag, "_S"}, 32'(s_sel), 32'(exp_s));
    check({tag, "_Cout"}, 32'(cout_sel), 32'(exp_cout));
    check({tag, "_V"}, 32'(v_sel), 32'(exp_v));
    last_s[sel]    = exp_s;
    last_cout[sel] = exp_cout;
    last_v[sel]    = exp_v;
  endtask

  task automatic directed(string tag, int idx, bit sb, logic [15:0] av, logic [15:0] bv,
                          bit cv, logic [15:0] es, bit ec, bit ev);
    launch(idx, sb, av, bv, cv);
    wait_done(tag, nch_of(idx));
    check({tag, "_S_const"}, 32'(s_sel), 32'(es));
    check({tag, "_Cout_const"}, 32'(cout_sel), 32'(ec));
    check({tag, "_V_const"}, 32'(v_sel), 32'(ev));
  endtask

  task automatic clear_last();
    for (int i = 0; i < 3; i++) begin
      last_s[i] = 16'h0000; last_cout[i] = 1'b0; last_v[i] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 3'b000; sub = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
    clear_last();
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("reset_busy", 32'(busy_sel), 32'd0);
      check("reset_done", 32'(done_sel), 32'd0);
      check("reset_S", 32'(s_sel), 32'd0);
      check("reset_Cout", 32'(cout_sel), 32'd0);
      check("reset_V", 32'(v_sel), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed add and subtract cases.
    directed("add_00ff", 0, 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    check("done_single_cycle", 32'(done_sel), 32'd0);
    directed("add_ffff", 0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_7fff", 0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("add_cin", 0, 1'b0, 16'h0F0F, 16'h00F0, 1'b1, 16'h1000, 1'b0, 1'b0);
    directed("sub_8000", 0, 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_0001", 0, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // A second start two cycles into RUN is ignored. Then a back-to-back
    // start in the done cycle is accepted.
    launch(0, 1'b0, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1; start[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 3'b000;
    wait_done("hs_first", 2);
    check("hs_first_const", 32'(s_sel), 32'h2345);
    launch(0, 1'b1, 16'h0005, 16'h0007, 1'b0);
    wait_done("hs_b2b", 4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      check("hs_no_extra_done", 32'(done_sel), 32'd0);
      check("hs_idle", 32'(busy_sel), 32'd0);
    end

    // Operand changes during RUN must not affect the result.
    launch(0, 1'b0, 16'h0F0F, 16'h00F1, 1'b1);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 16'h1357; b = 16'h2468; cin = 1'b1; sub = 1'b0;
    wait_done("hold", 3);
    check("hold_const", 32'(s_sel), 32'h1001);

    // Reset two cycles after start.
    launch(0, 1'b0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_sel), 32'd0);
    check("rst_mid_done", 32'(done_sel), 32'd0);
    check("rst_mid_S", 32'(s_sel), 32'd0);
    check("rst_mid_Cout", 32'(cout_sel), 32'd0);
    check("rst_mid_V", 32'(v_sel), 32'd0);
    clear_last();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_no_done", 32'(done_sel), 32'd0);
    end
    directed("post_rst", 0, 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Degenerate chunk sizes.
    directed("c16_add", 1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("c16_sub", 1, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    directed("n8_add", 2, 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("n8_sub", 2, 1'b1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b1, 1'b1);

    // Random operations on each configuration.
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); @(negedge clk);
        end
        launch(idx, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)));
        wait_done("rand", nch_of(idx));
      end
    end

    @(posedge clk); @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
